// File: rtl/data_bus_bridge_pkg.sv
// Shared widths, FSM state type and byte-lane legality rule for the data bus bridge.
// The width macros are defined here only if the shared bus header has not already provided them.
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef MEM_SEL_BUS_WIDTH
`define MEM_SEL_BUS_WIDTH 4
`endif

package data_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] STRB_ALL = 4'b1111;

  // Word, low halfword, high halfword, or a single byte sitting on its own lane.
  function automatic logic sel_addr_legal(input logic [3:0] sel, input logic [1:0] addr_lo);
    logic single_byte;
    single_byte = (sel == (4'b0001 << addr_lo));
    return ((sel == 4'b1111) && (addr_lo == 2'b00)) ||
           ((sel == 4'b0011) && (addr_lo == 2'b00)) ||
           ((sel == 4'b1100) && (addr_lo == 2'b10)) ||
           single_byte;
  endfunction

endpackage

// File: rtl/data_bus_bridge_mem_align_check.sv
// Combinational byte-lane / address alignment legality for one data access.
// Checking is active only when DATA_BUS_BRIDGE_ALIGN_CHECK_EN is defined; otherwise every access is legal.
module mem_align_check
  import data_bus_bridge_pkg::*;
(
  input  logic [`MEM_SEL_BUS_WIDTH-1:0] sel_i,
  input  logic [1:0]                    addr_lo_i,
  output logic                          legal_o
);

  logic rule_ok;

  assign rule_ok = sel_addr_legal(sel_i, addr_lo_i);

`ifdef DATA_BUS_BRIDGE_ALIGN_CHECK_EN
  assign legal_o = rule_ok;
`else
  // Rule is still evaluated so both builds share one netlist shape; the result is overridden.
  assign legal_o = rule_ok | 1'b1;
`endif

endmodule

// File: rtl/data_bus_bridge.sv
// Bridges single MEM-stage data accesses onto a valid/ready request + response bus, stalling the pipeline meanwhile.
// Optional alignment checking (addr_error_out pulse, request suppressed) with DATA_BUS_BRIDGE_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | no access in flight; a legal, unflushed mem_en_in issues one
// REQ   | request valid on the bus, payload held until accepted
// WAIT  | waiting for the response beat
// DONE  | one-cycle stall release toward the pipeline
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter bit WRITE_RESP = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_en_in,
  input  logic                          mem_write_flag_in,
  input  logic [`MEM_SEL_BUS_WIDTH-1:0] mem_sel_in,
  input  logic [`ADDR_BUS_WIDTH-1:0]    mem_addr_in,
  input  logic [`DATA_BUS_WIDTH-1:0]    mem_write_data_in,
  input  logic                          flush_in,
  output logic                          stall_request_out,
  output logic [`DATA_BUS_WIDTH-1:0]    ram_read_data_out,
  output logic                          addr_error_out,
  output logic                          bus_req_valid_out,
  input  logic                          bus_req_ready_in,
  output logic                          bus_req_write_out,
  output logic [`MEM_SEL_BUS_WIDTH-1:0] bus_req_strb_out,
  output logic [`ADDR_BUS_WIDTH-1:0]    bus_req_addr_out,
  output logic [`DATA_BUS_WIDTH-1:0]    bus_req_wdata_out,
  input  logic                          bus_resp_valid_in,
  input  logic [`DATA_BUS_WIDTH-1:0]    bus_resp_rdata_in,
  output logic                          bus_resp_ready_out
);

  state_e state_q, state_d;
  logic   discard_q, discard_d;

  logic                          wr_q;
  logic [`MEM_SEL_BUS_WIDTH-1:0] strb_q;
  logic [`ADDR_BUS_WIDTH-1:0]    addr_q;
  logic [`DATA_BUS_WIDTH-1:0]    wdata_q;
  logic [`DATA_BUS_WIDTH-1:0]    rdata_q;
  logic                          addr_err_q, addr_err_d;

  logic access_legal;
  logic issue;
  logic capture;
  logic kill_now;

  mem_align_check u_align (
    .sel_i     (mem_sel_in),
    .addr_lo_i (mem_addr_in[1:0]),
    .legal_o   (access_legal)
  );

  assign issue    = (state_q == ST_IDLE) & mem_en_in & ~flush_in & access_legal;
  assign kill_now = discard_q | flush_in;

`ifdef DATA_BUS_BRIDGE_ALIGN_CHECK_EN
  assign addr_err_d = (state_q == ST_IDLE) & mem_en_in & ~flush_in & ~access_legal;
`else
  assign addr_err_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    discard_d          = discard_q;
    capture            = 1'b0;
    stall_request_out  = 1'b0;
    bus_req_valid_out  = 1'b0;
    bus_resp_ready_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        discard_d         = 1'b0;
        stall_request_out = issue;
        if (issue) state_d = ST_REQ;
      end
      ST_REQ: begin
        stall_request_out = 1'b1;
        bus_req_valid_out = 1'b1;
        if (flush_in) discard_d = 1'b1;
        if (bus_req_ready_in) begin
          if (wr_q && !WRITE_RESP) state_d = kill_now ? ST_IDLE : ST_DONE;
          else                     state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_request_out  = 1'b1;
        bus_resp_ready_out = 1'b1;
        if (flush_in) discard_d = 1'b1;
        if (bus_resp_valid_in) begin
          // A flushed access still drains on the bus but never reaches the pipeline.
          state_d = kill_now ? ST_IDLE : ST_DONE;
          capture = ~wr_q & ~kill_now;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q       <= 1'b0;
      strb_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (issue) begin
        wr_q    <= mem_write_flag_in;
        strb_q  <= mem_write_flag_in ? mem_sel_in : STRB_ALL;
        addr_q  <= {mem_addr_in[`ADDR_BUS_WIDTH-1:2], 2'b00};
        wdata_q <= mem_write_data_in;
      end
      if (capture) rdata_q <= bus_resp_rdata_in;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus_req_write_out = wr_q;
  assign bus_req_strb_out  = strb_q;
  assign bus_req_addr_out  = addr_q;
  assign bus_req_wdata_out = wdata_q;
  assign ram_read_data_out = rdata_q;
  assign addr_error_out    = addr_err_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Self-checking bench for data_bus_bridge: directed scenarios plus randomized accesses against a transaction-level model.
module tb_data_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_wr, flush;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata;
  logic        req_ready, resp_valid;
  logic [31:0] rdata_in;
  logic        use_w0;

  logic        mem_en_a, mem_en_b;
  logic        stall_a, stall_b, aerr_a, aerr_b, valid_a, valid_b;
  logic        write_a, write_b, rr_a, rr_b;
  logic [3:0]  strb_a, strb_b;
  logic [31:0] addr_a, addr_b, wdata_a, wdata_b, rd_a, rd_b;

  logic        o_stall, o_aerr, o_valid, o_write, o_resp_ready;
  logic [3:0]  o_strb;
  logic [31:0] o_addr, o_wdata, o_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_rd [2];

  logic [3:0] sel_tab [7];
  logic [1:0] lo_tab  [7];
  int          k, rdl, pdl;
  bit          rb, rw;
  logic [31:0] ra;

  always #5 clk = ~clk;

  assign mem_en_a = mem_en & ~use_w0;
  assign mem_en_b = mem_en & use_w0;

  assign o_stall      = use_w0 ? stall_b : stall_a;
  assign o_aerr       = use_w0 ? aerr_b  : aerr_a;
  assign o_valid      = use_w0 ? valid_b : valid_a;
  assign o_write      = use_w0 ? write_b : write_a;
  assign o_resp_ready = use_w0 ? rr_b    : rr_a;
  assign o_strb       = use_w0 ? strb_b  : strb_a;
  assign o_addr       = use_w0 ? addr_b  : addr_a;
  assign o_wdata      = use_w0 ? wdata_b : wdata_a;
  assign o_rdata      = use_w0 ? rd_b    : rd_a;

  data_bus_bridge dut_a (
    .clk(clk), .rst(rst), .mem_en_in(mem_en_a), .mem_write_flag_in(mem_wr),
    .mem_sel_in(mem_sel), .mem_addr_in(mem_addr), .mem_write_data_in(mem_wdata),
    .flush_in(flush), .stall_request_out(stall_a), .ram_read_data_out(rd_a),
    .addr_error_out(aerr_a), .bus_req_valid_out(valid_a), .bus_req_ready_in(req_ready),
    .bus_req_write_out(write_a), .bus_req_strb_out(strb_a), .bus_req_addr_out(addr_a),
    .bus_req_wdata_out(wdata_a), .bus_resp_valid_in(resp_valid),
    .bus_resp_rdata_in(rdata_in), .bus_resp_ready_out(rr_a)
  );

  data_bus_bridge #(.WRITE_RESP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .mem_en_in(mem_en_b), .mem_write_flag_in(mem_wr),
    .mem_sel_in(mem_sel), .mem_addr_in(mem_addr), .mem_write_data_in(mem_wdata),
    .flush_in(flush), .stall_request_out(stall_b), .ram_read_data_out(rd_b),
    .addr_error_out(aerr_b), .bus_req_valid_out(valid_b), .bus_req_ready_in(req_ready),
    .bus_req_write_out(write_b), .bus_req_strb_out(strb_b), .bus_req_addr_out(addr_b),
    .bus_req_wdata_out(wdata_b), .bus_resp_valid_in(resp_valid),
    .bus_resp_rdata_in(rdata_in), .bus_resp_ready_out(rr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete access; the bus slave answers after rdelay/pdelay waiting cycles.
  task automatic do_access(input bit dut_b_sel, input bit wr, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input int rdelay, input int pdelay);
    int cyc, stalls, vcyc, rcnt, pcnt, exp_st;
    bit done, pay_bad, saw_rr, saw_aerr, wresp;
    logic [31:0] exp_addr, exp_rd;
    logic [3:0]  exp_strb;
    cyc = 0; stalls = 0; vcyc = 0; rcnt = 0; pcnt = 0;
    done = 0; pay_bad = 0; saw_rr = 0; saw_aerr = 0;
    wresp    = ~dut_b_sel;
    exp_addr = {addr[31:2], 2'b00};
    exp_strb = wr ? sel : 4'hF;
    exp_rd   = wr ? prev_rd[dut_b_sel] : rd;
    exp_st   = 1 + (rdelay + 1) + ((wr && !wresp) ? 0 : pdelay + 1);
    use_w0 = dut_b_sel;
    mem_en = 1'b1; mem_wr = wr; mem_sel = sel; mem_addr = addr; mem_wdata = wd;
    flush = 1'b0; rdata_in = rd;
    while (!done && cyc < 40) begin
      req_ready  = o_valid && (rcnt == rdelay);
      resp_valid = o_resp_ready && (pcnt == pdelay);
      @(negedge clk);
      if (o_stall) stalls++;
      if (o_aerr) saw_aerr = 1;
      if (o_resp_ready) saw_rr = 1;
      if (o_valid) begin
        vcyc++;
        if (o_addr !== exp_addr || o_strb !== exp_strb || o_write !== wr || o_wdata !== wd)
          pay_bad = 1;
        if (!req_ready) rcnt++;
      end
      if (o_resp_ready && !resp_valid) pcnt++;
      if (!o_stall) begin
        done = 1;
        chk("done_rdata", o_rdata, exp_rd);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("access_timeout", done, 1);
    chk("stall_cycles", stalls, exp_st);
    chk("valid_cycles", vcyc, rdelay + 1);
    chk("payload_stable", pay_bad, 0);
    chk("no_addr_error", saw_aerr, 0);
    if (wr && !wresp) chk("no_resp_ready", saw_rr, 0);
    mem_en = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
    @(negedge clk);
    chk("idle_after_done", o_stall, 0);
    chk("rdata_hold", o_rdata, exp_rd);
    prev_rd[dut_b_sel] = exp_rd;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sel_tab[0] = 4'b1111; lo_tab[0] = 2'b00;
    sel_tab[1] = 4'b0011; lo_tab[1] = 2'b00;
    sel_tab[2] = 4'b1100; lo_tab[2] = 2'b10;
    sel_tab[3] = 4'b0001; lo_tab[3] = 2'b00;
    sel_tab[4] = 4'b0010; lo_tab[4] = 2'b01;
    sel_tab[5] = 4'b0100; lo_tab[5] = 2'b10;
    sel_tab[6] = 4'b1000; lo_tab[6] = 2'b11;
    prev_rd[0] = '0; prev_rd[1] = '0;

    rst = 1'b0; mem_en = 1'b0; mem_wr = 1'b0; flush = 1'b0; mem_sel = '0;
    mem_addr = '0; mem_wdata = '0; req_ready = 1'b0; resp_valid = 1'b0;
    rdata_in = '0; use_w0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", o_stall, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_resp_ready", o_resp_ready, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_aerr", o_aerr, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Minimum-latency load.
    do_access(0, 0, 4'hF, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0);
    // Halfword store with a slow request acceptance.
    do_access(0, 1, 4'b1100, 32'h0000_2002, 32'hAB00_0000, 32'h1111_2222, 5, 0);
    // Store that completes on acceptance.
    do_access(1, 1, 4'b0011, 32'h0000_2100, 32'h0000_BEEF, 32'h3333_4444, 2, 0);

    // Flush in IDLE blocks issue.
    use_w0 = 1'b0; mem_en = 1'b1; flush = 1'b1; mem_wr = 1'b0; mem_sel = 4'hF;
    mem_addr = 32'h0000_6000;
    @(negedge clk);
    chk("flush_idle_stall", o_stall, 0);
    @(posedge clk); #1;
    mem_en = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_no_req", o_valid, 0);
    @(posedge clk); #1;

    // Flush while waiting for the response: drained, discarded, no DONE cycle.
    mem_en = 1'b1; mem_wr = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_4000;
    req_ready = 1'b1; resp_valid = 1'b0;
    @(negedge clk);
    chk("fl_issue_stall", o_stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fl_req_valid", o_valid, 1);
    @(posedge clk); #1;
    flush = 1'b1; mem_addr = 32'h0000_5008;
    @(negedge clk);
    chk("fl_wait_resp_ready", o_resp_ready, 1);
    @(posedge clk); #1;
    flush = 1'b0; resp_valid = 1'b1; rdata_in = 32'h1234_5678;
    @(negedge clk);
    chk("fl_wait_stall", o_stall, 1);
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    chk("fl_no_done", o_stall, 1);
    chk("fl_rdata_kept", o_rdata, prev_rd[0]);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fl_next_valid", o_valid, 1);
    chk("fl_next_addr", o_addr, 32'h0000_5008);
    @(posedge clk); #1;
    resp_valid = 1'b1; rdata_in = 32'h0BAD_C0DE;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    chk("fl_next_done", o_stall, 0);
    chk("fl_next_rdata", o_rdata, 32'h0BAD_C0DE);
    prev_rd[0] = 32'h0BAD_C0DE;
    @(posedge clk); #1;
    mem_en = 1'b0; req_ready = 1'b0;
    @(posedge clk); #1;

    // Misaligned lane select.
`ifdef DATA_BUS_BRIDGE_ALIGN_CHECK_EN
    mem_en = 1'b1; mem_wr = 1'b0; mem_sel = 4'b0110; mem_addr = 32'h0000_3001;
    @(negedge clk);
    chk("align_no_stall", o_stall, 0);
    chk("align_no_valid", o_valid, 0);
    @(posedge clk); #1;
    mem_en = 1'b0;
    @(negedge clk);
    chk("align_err_pulse", o_aerr, 1);
    chk("align_no_valid2", o_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("align_err_clear", o_aerr, 0);
    @(posedge clk); #1;
`else
    do_access(0, 0, 4'b0110, 32'h0000_3001, 32'h0, 32'h55AA_7788, 1, 1);
`endif

    // Reset while the request is outstanding.
    use_w0 = 1'b0; mem_en = 1'b1; mem_wr = 1'b0; mem_sel = 4'hF;
    mem_addr = 32'h0000_7000; req_ready = 1'b0;
    @(negedge clk);
    chk("rr_issue_stall", o_stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_req_valid", o_valid, 1);
    @(posedge clk); #1;
    rst = 1'b0; mem_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rr_valid", o_valid, 0);
    chk("rr_stall", o_stall, 0);
    chk("rr_resp_ready", o_resp_ready, 0);
    chk("rr_addr", o_addr, 0);
    chk("rr_strb", o_strb, 0);
    chk("rr_write", o_write, 0);
    chk("rr_wdata", o_wdata, 0);
    chk("rr_rdata", o_rdata, 0);
    chk("rr_aerr", o_aerr, 0);
    prev_rd[0] = '0; prev_rd[1] = '0;
    @(posedge clk); #1;
    do_access(0, 0, 4'hF, 32'h0000_7000, 32'h0, 32'h600D_F00D, 1, 2);

    for (int i = 0; i < 24; i++) begin
      k   = $urandom_range(0, 6);
      rdl = $urandom_range(0, 3);
      pdl = $urandom_range(0, 3);
      rb  = ($urandom_range(0, 3) == 0);
      rw  = $urandom_range(0, 1);
      ra  = $urandom;
      ra[1:0] = lo_tab[k];
      do_access(rb, rw, sel_tab[k], ra, $urandom, $urandom, rdl, pdl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_bridge.md
DATA_BUS_BRIDGE -- requirements
Module: data_bus_bridge

Interface
REQ-001 Parameter WRITE_RESP, default 1: 1 = writes wait for a bus response beat; 0 = writes complete on request acceptance.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 mem_en_in  in  1  MEM stage requests a data access this cycle.
REQ-005 mem_write_flag_in  in  1  1 = store, 0 = load.
REQ-006 mem_sel_in  in  `MEM_SEL_BUS_WIDTH (4)  byte-lane select.
REQ-007 mem_addr_in  in  `ADDR_BUS_WIDTH  byte address.
REQ-008 mem_write_data_in  in  `DATA_BUS_WIDTH  lane-aligned store data.
REQ-009 flush_in  in  1  pipeline flush; the current access is discarded.
REQ-010 stall_request_out  out  1  holds MEM and earlier stages.
REQ-011 ram_read_data_out  out  `DATA_BUS_WIDTH  load data toward MEMWB.
REQ-012 addr_error_out  out  1  misaligned-access pulse.
REQ-013 bus_req_valid_out / bus_req_ready_in  out/in  1  request handshake.
REQ-014 bus_req_write_out, bus_req_strb_out(4), bus_req_addr_out(32), bus_req_wdata_out(32)  out  request payload.
REQ-015 bus_resp_valid_in  in  1; bus_resp_rdata_in  in  32; bus_resp_ready_out  out  1  response handshake.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DONE.
REQ-017 IDLE: mem_en_in=1, flush_in=0 and access legal -> latch write flag, sel, {addr[31:2],2'b00}, wdata; next REQ.
REQ-018 REQ: bus_req_valid_out=1 with the latched payload held stable until bus_req_ready_in=1; then WAIT, or DONE for a write when WRITE_RESP=0.
REQ-019 WAIT: bus_resp_ready_out=1; on bus_resp_valid_in -> capture rdata into ram_read_data_out (loads only); next DONE.
REQ-020 DONE: stall_request_out=0 for exactly one cycle, ram_read_data_out stable; next IDLE unconditionally.
REQ-021 stall_request_out = (IDLE & mem_en_in & ~flush_in & legal) | REQ | WAIT, combinational.
REQ-022 Minimum access: 3 stall cycles + 1 DONE cycle, with ready and resp_valid both asserted in the first cycle they are sampled.
REQ-023 bus_req_write_out = latched write flag; bus_req_strb_out = latched sel for writes, 4'b1111 for reads.
REQ-024 flush_in in REQ/WAIT sets a discard flag; the transaction still completes on the bus; on completion go to IDLE (skip DONE); ram_read_data_out is not updated.
REQ-025 flush_in in DONE is ignored; flush_in in IDLE blocks request issue.
REQ-026 ram_read_data_out holds its value until the next captured load.
REQ-027 bus_req_valid_out never deasserts before acceptance, except at reset.

Reset
REQ-028 rst=0 at a clock edge: state IDLE, discard flag 0, ram_read_data_out 0, all handshake outputs 0, addr_error_out 0.
REQ-029 Reset mid-transaction abandons the transaction; the bus is reset from the same source.

Configuration
REQ-030 DATA_BUS_BRIDGE_ALIGN_CHECK_EN defined: legal sel/addr[1:0] pairs are 1111/00, 0011/00, 1100/10, and a single-byte sel matching addr[1:0]. Any other pair in IDLE with mem_en_in=1 issues no request, raises no stall, and pulses addr_error_out for 1 cycle.
REQ-031 Macro undefined: every access is legal, and addr_error_out is tied 0.

Structure
REQ-032 Widths `DATA_BUS_WIDTH, `ADDR_BUS_WIDTH and `MEM_SEL_BUS_WIDTH come from the shared bus.v header. FSM encodings are local constants.
REQ-033 Alignment legality lives in a combinational sub-module, mem_align_check.

Verification
REQ-034 Load addr 0x1004, sel 1111, ready and resp_valid immediate, rdata 0xDEADBEEF -> 3 stall cycles, then DONE with ram_read_data_out=0xDEADBEEF.
REQ-035 Store addr 0x2002, sel 1100, wdata 0xAB000000, ready delayed 5 cycles -> valid held and payload stable for 5 cycles, addr 0x2000, strb 1100, stall released once.
REQ-036 WRITE_RESP=0 store -> DONE follows acceptance directly, and bus_resp_ready_out is never asserted.
REQ-037 flush_in in WAIT, load rdata 0x12345678 -> returns to IDLE with no DONE cycle, and ram_read_data_out keeps its prior value.
REQ-038 ALIGN_CHECK_EN: sel 0110 at addr 0x3001 -> addr_error_out=1 for 1 cycle, no bus_req_valid_out, no stall. Macro off: the request is issued to addr 0x3000.
REQ-039 rst=0 during REQ -> next cycle IDLE with all outputs 0. The next load completes normally.
